shift_reg_univ: RTL and testbench
=================================

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1), burst-count width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port en  input  1  clock enable; low means all state holds.
REQ-006 The block SHALL have port mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-008 The block SHALL have port sin_r  input  1  serial bit entering q[WIDTH-1] on a right shift.
REQ-009 The block SHALL have port sin_l  input  1  serial bit entering q[0] on a left shift.
REQ-010 The block SHALL have port start  input  1  single-cycle request for an automatic burst shift.
REQ-011 The block SHALL have port nshift  input  CNT_W  number of shifts in the burst.
REQ-012 The block SHALL have port q  output  WIDTH  register contents.
REQ-013 The block SHALL have port sout_r / sout_l  output  1 each  q[0] / q[WIDTH-1].
REQ-014 The block SHALL have port busy / done  output  1 each  burst in progress / burst-finished pulse.

Function
REQ-015 In IDLE, with en=1 and start=0, q SHALL update per mode on the next edge: right {sin_r,q[WIDTH-1:1]}, left {q[WIDTH-2:0],sin_l}, load d, hold q.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; busy=1 only in BUSY, done=1 only in DONE.
REQ-017 IDLE with en=1, start=1, mode 01/10, nshift>0 SHALL latch direction and nshift, perform the first shift on that edge, and enter BUSY if nshift>1, else DONE.
REQ-018 IDLE with en=1, start=1, nshift=0 SHALL leave q unchanged and enter DONE.
REQ-019 IDLE with start=1 and mode 00/11 SHALL ignore start and execute mode as in REQ-015.
REQ-020 In BUSY, each edge with en=1 SHALL perform one shift in the latched direction using live sin_r/sin_l; after the nshift-th shift, state SHALL become DONE.
REQ-021 In BUSY, mode, d, start and nshift SHALL be ignored; en=0 SHALL stall state, q and the remaining count.
REQ-022 DONE SHALL last exactly one cycle regardless of en, then return to IDLE; mode operations SHALL be blocked in DONE.
REQ-023 nshift values greater than WIDTH SHALL be honoured literally (serial data streams through).

Reset
REQ-024 rst=1 at a rising edge SHALL force q=0, state IDLE, count 0, busy=0, done=0, overriding en, start and mode.
REQ-025 Reset asserted during BUSY SHALL abort the burst with no done pulse.

Configuration
REQ-026 With macro SHIFT_REG_ROTATE_EN defined, an extra input rot (1 bit) SHALL exist; rot=1 makes all shifts (manual and burst) rotate (q[0] into MSB on right, q[WIDTH-1] into LSB on left), ignoring sin_r/sin_l.
REQ-027 Without SHIFT_REG_ROTATE_EN, the rot port and rotate logic SHALL be absent and shifts SHALL always use the serial inputs.

Structure
REQ-028 Mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and FSM state encodings SHALL live in shared package shift_reg_pkg.
REQ-029 The burst counter/FSM SHALL be a sub-module shift_burst_ctrl; the datapath stays in shift_reg_univ.

Verification (WIDTH=4, 10-unit clock period)
REQ-030 rst pulse, then mode=11 d=1010 en=1 -> q=1010 one edge later; en=0 for 3 edges -> q stays 1010.
REQ-031 q=1010, mode=01 sin_r=1 two edges -> q=1101 then 1110; mode=10 sin_l=0 one edge -> q=1100.
REQ-032 q=0001, start=1 mode=10 nshift=3 sin_l=0 -> busy high 2 cycles, q=1000 after third edge, done high exactly one cycle, then IDLE.
REQ-033 Burst nshift=3 with en=0 for 2 cycles mid-burst -> completion delayed by 2 cycles, final q unchanged from REQ-032; start=1 during BUSY ignored.
REQ-034 rst=1 during BUSY -> next edge q=0000, busy=0, done never asserted; nshift=0 start -> done pulse, q unchanged.
REQ-035 With SHIFT_REG_ROTATE_EN, q=1001 rot=1 mode=01 one edge -> q=1100; start nshift=4 -> q returns to 1100.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared mode and burst-state encodings for the universal shift register
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } burst_state_t;

    function automatic logic is_shift_mode(input logic [1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// rtl/shift_burst_ctrl.sv - burst counter/FSM deciding when the datapath shifts, loads or holds
module shift_burst_ctrl
    import shift_reg_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
    output logic             shift_en,
    output logic             shift_left,
    output logic             manual_en,
    output logic             busy,
    output logic             done
);

    burst_state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dir_left, dir_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dir_left <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            dir_left <= dir_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir_left;
        shift_en   = 1'b0;
        shift_left = dir_left;
        manual_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    if (start && is_shift_mode(mode)) begin
                        if (nshift == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            // first shift of the burst happens on the accepting edge
                            shift_en   = 1'b1;
                            shift_left = (mode == MODE_SHL);
                            dir_next   = (mode == MODE_SHL);
                            cnt_next   = nshift - CNT_W'(1);
                            state_next = (nshift > CNT_W'(1)) ? ST_BUSY : ST_DONE;
                        end
                    end else begin
                        manual_en = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (en) begin
                    shift_en = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with automatic burst shifting
// Optional SHIFT_REG_ROTATE_EN adds input rot to turn every shift into a rotate.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic shift_en, shift_left, manual_en;
    logic in_r, in_l;
    logic [WIDTH-1:0] q_shr, q_shl;

    shift_burst_ctrl #(
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .nshift    (nshift),
        .shift_en  (shift_en),
        .shift_left(shift_left),
        .manual_en (manual_en),
        .busy      (busy),
        .done      (done)
    );

`ifdef SHIFT_REG_ROTATE_EN
    assign in_r = rot ? q[0]       : sin_r;
    assign in_l = rot ? q[WIDTH-1] : sin_l;
`else
    assign in_r = sin_r;
    assign in_l = sin_l;
`endif

    assign q_shr = {in_r, q[WIDTH-1:1]};
    assign q_shl = {q[WIDTH-2:0], in_l};

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= shift_left ? q_shl : q_shr;
        end else if (manual_en) begin
            case (mode)
                MODE_SHR:  q <= q_shr;
                MODE_SHL:  q <= q_shl;
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - directed self-checking bench for shift_reg_univ (WIDTH=4)
module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       rst, en, sin_r, sin_l, start;
    logic [1:0] mode;
    logic [3:0] d;
    logic [2:0] nshift;
    logic       rot;
    logic [3:0] q;
    logic       sout_r, sout_l, busy, done;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .start (start),
        .nshift(nshift),
`ifdef SHIFT_REG_ROTATE_EN
        .rot   (rot),
`endif
        .q     (q),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .busy  (busy),
        .done  (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] v);
        en = 1'b1; start = 1'b0; mode = 2'b11; d = v;
        tick();
        check("load", {4'h0, q}, {4'h0, v});
        mode = 2'b00;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b11; d = 4'hF; sin_r = 1'b0; sin_l = 1'b0;
        start = 1'b1; nshift = 3'd2; rot = 1'b0;
        tick();
        check("rst_q", {4'h0, q}, 8'h00);
        check("rst_busy", {7'h0, busy}, 8'h00);
        check("rst_done", {7'h0, done}, 8'h00);
        rst = 1'b0; start = 1'b0;

        // load and hold with en low
        mode = 2'b11; d = 4'b1010;
        tick();
        check("load_1010", {4'h0, q}, 8'h0A);
        check("sout_r", {7'h0, sout_r}, 8'h00);
        check("sout_l", {7'h0, sout_l}, 8'h01);
        en = 1'b0; d = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_low_hold", {4'h0, q}, 8'h0A);
        end

        // manual shifts
        en = 1'b1; mode = 2'b01; sin_r = 1'b1;
        tick(); check("shr1", {4'h0, q}, 8'h0D);
        tick(); check("shr2", {4'h0, q}, 8'h0E);
        mode = 2'b10; sin_l = 1'b0;
        tick(); check("shl1", {4'h0, q}, 8'h0C);
        mode = 2'b00;
        tick(); check("hold", {4'h0, q}, 8'h0C);

        // burst left by 3
        load(4'b0001);
        start = 1'b1; mode = 2'b10; nshift = 3'd3; sin_l = 1'b0;
        tick();
        check("b1_q", {4'h0, q}, 8'h02);
        check("b1_busy", {7'h0, busy}, 8'h01);
        start = 1'b0; mode = 2'b00;
        tick();
        check("b2_q", {4'h0, q}, 8'h04);
        check("b2_busy", {7'h0, busy}, 8'h01);
        tick();
        check("b3_q", {4'h0, q}, 8'h08);
        check("b3_busy", {7'h0, busy}, 8'h00);
        check("b3_done", {7'h0, done}, 8'h01);
        mode = 2'b11; d = 4'b1111;
        tick();
        check("after_done", {7'h0, done}, 8'h00);
        check("done_blocks_mode", {4'h0, q}, 8'h08);
        mode = 2'b00;

        // burst with stall and ignored start
        load(4'b0001);
        start = 1'b1; mode = 2'b10; nshift = 3'd3;
        tick();
        check("s1_q", {4'h0, q}, 8'h02);
        start = 1'b0; en = 1'b0;
        tick(); tick();
        check("stall_q", {4'h0, q}, 8'h02);
        check("stall_busy", {7'h0, busy}, 8'h01);
        en = 1'b1; start = 1'b1; mode = 2'b11; d = 4'b1111; nshift = 3'd1;
        tick();
        check("s2_q", {4'h0, q}, 8'h04);
        check("s2_busy", {7'h0, busy}, 8'h01);
        start = 1'b0; mode = 2'b00;
        tick();
        check("s3_q", {4'h0, q}, 8'h08);
        check("s3_done", {7'h0, done}, 8'h01);
        tick();
        check("s_idle", {1'b0, 5'h0, busy, done}, 8'h00);

        // reset aborts a burst
        load(4'b0001);
        start = 1'b1; mode = 2'b01; nshift = 3'd3; sin_r = 1'b1;
        tick();
        check("r1_q", {4'h0, q}, 8'h08);
        start = 1'b0; rst = 1'b1;
        tick();
        check("abort_q", {4'h0, q}, 8'h00);
        check("abort_busy", {7'h0, busy}, 8'h00);
        check("abort_done", {7'h0, done}, 8'h00);
        rst = 1'b0; mode = 2'b00;
        tick();
        check("abort_no_done", {7'h0, done}, 8'h00);

        // zero-length burst
        load(4'b0110);
        start = 1'b1; mode = 2'b01; nshift = 3'd0;
        tick();
        check("z_q", {4'h0, q}, 8'h06);
        check("z_done", {6'h0, busy, done}, 8'h01);
        start = 1'b0; mode = 2'b00;
        tick();
        check("z_after", {7'h0, done}, 8'h00);

        // burst longer than WIDTH streams serial data with live sin_r
        load(4'b0000);
        start = 1'b1; mode = 2'b01; nshift = 3'd6; sin_r = 1'b1;
        tick(); check("l1", {4'h0, q}, 8'h08);
        start = 1'b0; mode = 2'b00; sin_r = 1'b0;
        tick(); check("l2", {4'h0, q}, 8'h04);
        sin_r = 1'b1;
        tick(); check("l3", {4'h0, q}, 8'h0A);
        tick(); check("l4", {4'h0, q}, 8'h0D);
        sin_r = 1'b0;
        tick(); check("l5", {4'h0, q}, 8'h06);
        check("l5_busy", {7'h0, busy}, 8'h01);
        sin_r = 1'b1;
        tick(); check("l6", {4'h0, q}, 8'h0B);
        check("l6_done", {6'h0, busy, done}, 8'h01);
        tick();

        // start ignored in load mode
        start = 1'b1; mode = 2'b11; d = 4'b0101; nshift = 3'd2;
        tick();
        check("start_load_q", {4'h0, q}, 8'h05);
        check("start_load_fsm", {6'h0, busy, done}, 8'h00);
        start = 1'b0; mode = 2'b00;

`ifdef SHIFT_REG_ROTATE_EN
        load(4'b1001);
        rot = 1'b1; mode = 2'b01; sin_r = 1'b0;
        tick();
        check("rot_shr", {4'h0, q}, 8'h0C);
        start = 1'b1; nshift = 3'd4;
        tick(); check("rot_b1", {4'h0, q}, 8'h06);
        start = 1'b0; mode = 2'b00;
        tick(); check("rot_b2", {4'h0, q}, 8'h03);
        tick(); check("rot_b3", {4'h0, q}, 8'h09);
        tick();
        check("rot_b4", {4'h0, q}, 8'h0C);
        check("rot_done", {7'h0, done}, 8'h01);
        rot = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
